// File: rtl/ultra_sonic_pkg.sv
// Shared definitions for the ultrasonic trigger/echo blocks: echo emulator
// FSM states, counter width and 50 MHz timing defaults.
package ultra_sonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } echo_state_e;

    localparam int unsigned COUNT_W = 32'd23;

    // Sensor timing at 50 MHz: 10 us trigger, 40 kHz burst, 38 ms no-object echo
    localparam int unsigned DEF_MIN_TRIG    = 32'd500;
    localparam int unsigned DEF_BURST_DELAY = 32'd10000;
    localparam int unsigned DEF_TIMEOUT     = 32'd1900000;
    localparam int unsigned DEF_HOLDOFF     = 32'd500000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ultra_sonic_echo_emu.sv
// Ultrasonic range sensor emulator: validates a trigger pulse, waits a burst
// delay, then returns an echo pulse of programmable width followed by a dead time.
module ultra_sonic_echo_emu
    import ultra_sonic_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNT_W,
    parameter int unsigned MIN_TRIG    = DEF_MIN_TRIG,
    parameter int unsigned BURST_DELAY = DEF_BURST_DELAY,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned HOLDOFF     = DEF_HOLDOFF
) (
    input  logic             clk,
    input  logic             reset_all,
    input  logic             enable,
    input  logic             trig_in,
    input  logic [WIDTH-1:0] echo_len,
    output logic             echo_out,
    output logic             busy,
    output logic             done,
    output logic             trig_err
);

    localparam longint unsigned CNT_MAX = (64'd1 << WIDTH) - 64'd1;

    if ((64'(MIN_TRIG) > CNT_MAX) || (64'(BURST_DELAY) > CNT_MAX) ||
        (64'(TIMEOUT) > CNT_MAX) || (64'(HOLDOFF) > CNT_MAX)) begin : g_param_range
        $error("ultra_sonic_echo_emu: timing parameter exceeds counter range");
    end

    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_TRIG_C = WIDTH'(MIN_TRIG);
    localparam logic [WIDTH-1:0] BURST_C   = WIDTH'(BURST_DELAY);
    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] HOLDOFF_C = WIDTH'(HOLDOFF);

    // Out-of-range requests (0 or beyond the no-object width) read as "no object"
    function automatic logic [WIDTH-1:0] clamp_len(input logic [WIDTH-1:0] len);
        if ((len == ZERO) || (len > TIMEOUT_C)) begin
            return TIMEOUT_C;
        end else begin
            return len;
        end
    endfunction

    echo_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             echo_q, echo_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             trig_s;
    logic             trig_prev_q;

    sync_2ff u_trig_sync (
        .clk_i (clk),
        .rst_i (reset_all),
        .d_i   (trig_in),
        .q_o   (trig_s)
    );

    // State, shared phase counter, latched echo width and registered outputs
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO;
            len_q       <= ZERO;
            echo_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            echo_q      <= echo_d;
            done_q      <= done_d;
            err_q       <= err_d;
            trig_prev_q <= trig_s;
        end
    end

    // Next-state logic; cnt_q holds the trigger-high count in TRIG and the elapsed phase time elsewhere
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        echo_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && trig_s && !trig_prev_q) begin
                    state_d = ST_TRIG;
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = ZERO;
                end
            end
            ST_TRIG: begin
                if (trig_s) begin
                    cnt_d = (cnt_q < MIN_TRIG_C) ? cnt_q + ONE : cnt_q;
                end else if (cnt_q >= MIN_TRIG_C) begin
                    len_d   = clamp_len(echo_len);
                    state_d = ST_BURST;
                    cnt_d   = ZERO;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end
            end
            ST_BURST: begin
                if (cnt_q + ONE >= BURST_C) begin
                    state_d = ST_ECHO;
                    cnt_d   = ZERO;
                    echo_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ONE;
                end
            end
            ST_ECHO: begin
                if (cnt_q + ONE >= len_q) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ONE;
                    echo_d  = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q + ONE >= HOLDOFF_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end else begin
                    cnt_d   = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    assign echo_out = echo_q;
    assign done     = done_q;
    assign trig_err = err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultra_sonic_echo_emu.sv
// Directed table-driven bench for ultra_sonic_echo_emu with shortened timing
// (MIN_TRIG=4, BURST_DELAY=3, TIMEOUT=20, HOLDOFF=5).
module tb_ultra_sonic_echo_emu;

    localparam int W   = 23;
    localparam int WIN = 50;

    logic         clk = 1'b0;
    logic         reset_all;
    logic         enable;
    logic         trig_in;
    logic [W-1:0] echo_len;
    logic         echo_out;
    logic         busy;
    logic         done;
    logic         trig_err;

    int total = 0;
    int bad   = 0;

    ultra_sonic_echo_emu #(
        .WIDTH       (W),
        .MIN_TRIG    (4),
        .BURST_DELAY (3),
        .TIMEOUT     (20),
        .HOLDOFF     (5)
    ) dut (
        .clk       (clk),
        .reset_all (reset_all),
        .enable    (enable),
        .trig_in   (trig_in),
        .echo_len  (echo_len),
        .echo_out  (echo_out),
        .busy      (busy),
        .done      (done),
        .trig_err  (trig_err)
    );

    always #5 clk = ~clk;

    // Cycle n = samples taken after the n-th rising edge since trig_in first goes high.
    typedef struct {
        int          hi;
        int          len;
        int          len2;
        logic [63:0] extra;
        bit          en;
        int          en_off;
        int          e_rise;
        int          e_width;
        int          e_pulses;
        int          e_done;
        int          e_done_cyc;
        int          e_err_cyc;
        int          e_busy_rises;
        int          e_busy_end;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int rise = 0, width = 0, pulses = 0, dcnt = 0, dcyc = 0;
        int ecnt = 0, ecyc = 0, brises = 0, bend = 0;
        logic echo_p, busy_p;
        echo_p = echo_out;
        busy_p = busy;
        @(negedge clk);
        for (int n = 1; n <= WIN + 1; n++) begin
            if (n > 1) begin
                @(negedge clk);
                if (echo_out && !echo_p) begin
                    pulses++;
                    if (rise == 0) rise = n - 1;
                end
                if (echo_out) width++;
                if (done) begin dcnt++; dcyc = n - 1; end
                if (trig_err) begin ecnt++; ecyc = n - 1; end
                if (busy && !busy_p) brises++;
                if (!busy && busy_p) bend = n - 1;
                echo_p = echo_out;
                busy_p = busy;
            end
            trig_in  = (n <= v.hi) || ((n < 64) && v.extra[n]);
            echo_len = (n <= v.hi + 3) ? W'(v.len) : W'(v.len2);
            enable   = v.en && ((v.en_off == 0) || (n < v.en_off));
        end
        check({name, " rise_cycle"}, rise, v.e_rise);
        check({name, " echo_width"}, width, v.e_width);
        check({name, " echo_pulses"}, pulses, v.e_pulses);
        check({name, " done_count"}, dcnt, v.e_done);
        check({name, " done_cycle"}, dcyc, v.e_done_cyc);
        check({name, " err_count"}, ecnt, (v.e_err_cyc != 0) ? 1 : 0);
        check({name, " err_cycle"}, ecyc, v.e_err_cyc);
        check({name, " busy_rises"}, brises, v.e_busy_rises);
        check({name, " busy_end"}, bend, v.e_busy_end);
    endtask

    initial begin
        int ecnt;
        int dcnt;
        //            hi len len2 extra  en off rise wid pul don dcyc err br bend
        vecs[0]  = '{6, 7,   15, 64'd0, 1'b1, 0, 12,  7, 1, 1, 19, 0, 1, 24};
        vecs[1]  = '{2, 7,   7,  64'd0, 1'b1, 0,  0,  0, 0, 0,  0, 5, 1,  5};
        vecs[2]  = '{3, 5,   5,  64'd0, 1'b1, 0,  0,  0, 0, 0,  0, 6, 1,  6};
        vecs[3]  = '{4, 1,   1,  64'd0, 1'b1, 0, 10,  1, 1, 1, 11, 0, 1, 16};
        vecs[4]  = '{6, 0,   0,  64'd0, 1'b1, 0, 12, 20, 1, 1, 32, 0, 1, 37};
        vecs[5]  = '{6, 100, 100,64'd0, 1'b1, 0, 12, 20, 1, 1, 32, 0, 1, 37};
        vecs[6]  = '{6, 20,  20, 64'd0, 1'b1, 0, 12, 20, 1, 1, 32, 0, 1, 37};
        vecs[7]  = '{6, 21,  21, 64'd0, 1'b1, 0, 12, 20, 1, 1, 32, 0, 1, 37};
        vecs[8]  = '{6, 7,   7,  64'd0, 1'b0, 0,  0,  0, 0, 0,  0, 0, 0,  0};
        vecs[9]  = '{6, 7,   2,  64'd0, 1'b1, 5, 12,  7, 1, 1, 19, 0, 1, 24};
        vecs[10] = '{6, 7,   7,  (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 15) |
                                 (64'h3F << 19), 1'b1, 0, 12, 7, 1, 1, 19, 0, 1, 24};

        reset_all = 1'b1;
        enable    = 1'b0;
        trig_in   = 1'b0;
        echo_len  = '0;
        repeat (3) @(negedge clk);
        check("reset echo_out", int'(echo_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset trig_err", int'(trig_err), 0);
        reset_all = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset three clocks into the echo: echo must drop without waiting for a clock edge
        @(negedge clk);
        for (int n = 1; n <= 14; n++) begin
            trig_in  = (n <= 6);
            echo_len = W'(7);
            @(negedge clk);
        end
        check("pre-reset echo_out", int'(echo_out), 1);
        #2;
        reset_all = 1'b1;
        #1;
        check("async reset echo_out", int'(echo_out), 0);
        check("async reset busy", int'(busy), 0);
        @(negedge clk);
        reset_all = 1'b0;
        ecnt = 0;
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (echo_out || busy) ecnt++;
            if (done) dcnt++;
        end
        check("post-reset activity", ecnt, 0);
        check("post-reset done", dcnt, 0);
        run_vec(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
